// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: PC register, 2-bit BHT direction predictor,
// next-PC mux, Execute-stage branch resolution and performance counters.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IDX_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        branch_E,
    input  logic        jump_E,
    input  logic        taken_E,
    input  logic [31:0] pc_E,
    input  logic [31:0] pc_target_E,
    input  logic        pred_taken_E,
    input  logic [31:0] pred_target_E,
    output logic [31:0] pc_F,
    output logic        pred_taken_F,
    output logic [31:0] pred_target_F,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam int unsigned BHT_N    = 1 << IDX_W;
    localparam logic [1:0]  WEAK_NT  = 2'b01;
    localparam logic [1:0]  STRONG_T = 2'b11;
    localparam logic [1:0]  STRONG_N = 2'b00;

    logic [1:0]       bht [BHT_N];
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic             res;
    logic             act_taken;
    logic [31:0]      pc_e_plus4;
    logic [31:0]      act_next;
    logic [1:0]       bht_cur_e;
    logic [1:0]       bht_nxt_e;
    logic [31:0]      pc_nxt;

    assign idx_f = pc_F[IDX_W+1:2];
    assign idx_e = pc_E[IDX_W+1:2];

    // Prediction uses the pre-edge BHT value; no bypass from the Execute write.
    assign pred_taken_F  = btb_hit & bht[idx_f][1];
    assign pred_target_F = btb_target;

    // Execute-stage resolution and mispredict detection.
    always_comb begin
        res        = branch_E | jump_E;
        act_taken  = jump_E | taken_E;
        pc_e_plus4 = pc_E + 32'd4;
        act_next   = (res & act_taken) ? pc_target_E : pc_e_plus4;
        mispredict = (res & (pred_taken_E != act_taken))
                   | (res & act_taken & pred_taken_E & (pred_target_E != pc_target_E))
                   | (~res & pred_taken_E);
        redirect_pc = act_next;
    end

    // Saturating 2-bit counter update for the resolving instruction.
    always_comb begin
        bht_cur_e = bht[idx_e];
        bht_nxt_e = bht_cur_e;
        if (jump_E) begin
            bht_nxt_e = STRONG_T;
        end else if (taken_E) begin
            bht_nxt_e = (bht_cur_e == STRONG_T) ? STRONG_T : bht_cur_e + 2'd1;
        end else begin
            bht_nxt_e = (bht_cur_e == STRONG_N) ? STRONG_N : bht_cur_e - 2'd1;
        end
    end

    // Next-PC priority: redirect overrides stall, then BTB prediction, then sequential.
    always_comb begin
        pc_nxt = pc_F + 32'd4;
        if (mispredict) begin
            pc_nxt = redirect_pc;
        end else if (stall_F) begin
            pc_nxt = pc_F;
        end else if (pred_taken_F) begin
            pc_nxt = btb_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_F     <= RESET_PC;
            br_count <= 32'd0;
            mp_count <= 32'd0;
        end else begin
            pc_F <= pc_nxt;
            if (res) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict) begin
                mp_count <= mp_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_N); i++) begin
                bht[i] <= WEAK_NT;
            end
        end else if (res) begin
            bht[idx_e] <= bht_nxt_e;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus randomized
// traffic against a behavioural model of the fetch/predict/resolve rules.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall_F;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        branch_E;
    logic        jump_E;
    logic        taken_E;
    logic [31:0] pc_E;
    logic [31:0] pc_target_E;
    logic        pred_taken_E;
    logic [31:0] pred_target_E;
    logic [31:0] pc_F;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned m_pc;
    int unsigned m_br;
    int unsigned m_mp;
    int          m_bht [256];

    fetch_pc_gen #(.RESET_PC(32'h0000_0000), .IDX_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_F       (stall_F),
        .btb_hit       (btb_hit),
        .btb_target    (btb_target),
        .branch_E      (branch_E),
        .jump_E        (jump_E),
        .taken_E       (taken_E),
        .pc_E          (pc_E),
        .pc_target_E   (pc_target_E),
        .pred_taken_E  (pred_taken_E),
        .pred_target_E (pred_target_E),
        .pc_F          (pc_F),
        .pred_taken_F  (pred_taken_F),
        .pred_target_F (pred_target_F),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .mp_count      (mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bidx(input int unsigned pc);
        return int'((pc >> 2) % 256);
    endfunction

    function automatic bit m_mispredict();
        bit actual;
        if (!(branch_E || jump_E)) return pred_taken_E;
        actual = jump_E || taken_E;
        if (pred_taken_E != actual) return 1'b1;
        if (actual && pred_target_E != pc_target_E) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int unsigned m_redirect();
        if ((branch_E || jump_E) && (jump_E || taken_E)) return pc_target_E;
        return pc_E + 4;
    endfunction

    function automatic bit m_pred();
        return btb_hit && (m_bht[bidx(m_pc)] >= 2);
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_br = 0;
        m_mp = 0;
        for (int i = 0; i < 256; i++) m_bht[i] = 1;
    endtask

    task automatic clear_inputs();
        stall_F = 0; btb_hit = 0; btb_target = 0;
        branch_E = 0; jump_E = 0; taken_E = 0;
        pc_E = 0; pc_target_E = 0; pred_taken_E = 0; pred_target_E = 0;
    endtask

    // Advance one clock, evolving the model from the inputs held during the cycle.
    task automatic step();
        int unsigned nxt;
        int          i;
        if (rst) begin
            @(posedge clk); #1;
            model_reset();
            return;
        end
        if (m_mispredict())   nxt = m_redirect();
        else if (stall_F)     nxt = m_pc;
        else if (m_pred())    nxt = btb_target;
        else                  nxt = m_pc + 4;
        if (branch_E || jump_E) begin
            i = bidx(pc_E);
            if (jump_E)       m_bht[i] = 3;
            else if (taken_E) m_bht[i] = (m_bht[i] + 1 > 3) ? 3 : m_bht[i] + 1;
            else              m_bht[i] = (m_bht[i] - 1 < 0) ? 0 : m_bht[i] - 1;
            m_br++;
        end
        if (m_mispredict()) m_mp++;
        @(posedge clk); #1;
        m_pc = nxt;
    endtask

    // Steer fetch to an arbitrary address via a BTB-alias mispredict.
    task automatic goto_pc(input logic [31:0] target);
        clear_inputs();
        pred_taken_E = 1;
        pc_E = target - 32'd4;
        step();
        clear_inputs();
    endtask

    task automatic pulse_reset();
        rst = 1; #1;
        clear_inputs();
        step();
        #2 rst = 0;
    endtask

    task automatic test_reset();
        rst = 0; clear_inputs();
        #1 rst = 1;
        #1;
        checks++; if (pc_F !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_F, 32'h0); end
        checks++; if (br_count !== 32'h0 || mp_count !== 32'h0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", br_count, mp_count); end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        // train index 0 to strongly taken without redirecting
        stall_F = 1; branch_E = 1; taken_E = 1; pc_E = 0;
        pc_target_E = 32'h8; pred_taken_E = 1; pred_target_E = 32'h8;
        step(); step();
        clear_inputs();
        btb_hit = 1; btb_target = 32'h40; #1;
        checks++; if (pred_taken_F !== 1'b1) begin errors++; $display("FAIL trained_pred got=%b exp=1", pred_taken_F); end
        step();
        btb_hit = 0;
        checks++; if (pc_F !== 32'h40) begin errors++; $display("FAIL pred_fetch got=%h exp=%h", pc_F, 32'h40); end
        checks++; if (br_count !== 32'd2) begin errors++; $display("FAIL br_pre_reset got=%0d exp=2", br_count); end
        // async reset mid-cycle with a resolution in flight
        rst = 1; #1;
        checks++; if (pc_F !== 32'h0) begin errors++; $display("FAIL midrun_reset_pc got=%h exp=0", pc_F); end
        checks++; if (br_count !== 32'h0 || mp_count !== 32'h0) begin errors++; $display("FAIL midrun_reset_cnt got=%0d/%0d exp=0/0", br_count, mp_count); end
        branch_E = 1; jump_E = 1; pc_E = 32'h40; pred_taken_E = 1; pred_target_E = 32'h99;
        step();
        #2 rst = 0;
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            btb_hit = 1; btb_target = 32'h300; #1;
            checks++; if (pred_taken_F !== 1'b0) begin errors++; $display("FAIL post_reset_pred pc=%h got=%b exp=0", pc_F, pred_taken_F); end
            step();
        end
        checks++; if (pc_F !== 32'h20 || br_count !== 32'd0) begin errors++; $display("FAIL post_reset_run pc=%h br=%0d exp=00000020/0", pc_F, br_count); end
        clear_inputs();
    endtask

    task automatic test_sequential_stall();
        logic [31:0] exp_seq [5];
        exp_seq = '{32'h10, 32'h10, 32'h10, 32'h14, 32'h18};
        goto_pc(32'h10);
        for (int k = 0; k < 5; k++) begin
            checks++; if (pc_F !== exp_seq[k]) begin errors++; $display("FAIL seq_stall[%0d] got=%h exp=%h", k, pc_F, exp_seq[k]); end
            stall_F = (k < 2);
            step();
        end
        clear_inputs();
    endtask

    task automatic test_training();
        logic exp_p [6];
        exp_p = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        pulse_reset();
        goto_pc(32'h100);
        stall_F = 1; btb_hit = 1; btb_target = 32'h200;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (pred_taken_F !== exp_p[k] || pred_taken_F !== m_pred()) begin errors++; $display("FAIL train[%0d] got=%b exp=%b", k, pred_taken_F, exp_p[k]); end
            if (k == 5) break;
            branch_E = 1; pc_E = 32'h100; taken_E = (k < 3);
            pred_taken_E = (k < 3); pc_target_E = 32'h200; pred_target_E = 32'h200;
            step();
        end
        checks++; if (pred_target_F !== 32'h200 || pc_F !== 32'h100) begin errors++; $display("FAIL train_hold tgt=%h pc=%h exp=200/100", pred_target_F, pc_F); end
        clear_inputs();
    endtask

    task automatic test_mispredict();
        pulse_reset();
        stall_F = 1; branch_E = 1; taken_E = 1; pc_E = 32'h80;
        pc_target_E = 32'h40; pred_taken_E = 0; #1;
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h40) begin errors++; $display("FAIL mp_detect mp=%b rd=%h exp=1/40", mispredict, redirect_pc); end
        step();
        clear_inputs();
        checks++; if (pc_F !== 32'h40) begin errors++; $display("FAIL mp_redirect got=%h exp=40", pc_F); end
        checks++; if (mp_count !== 32'd1 || br_count !== 32'd1) begin errors++; $display("FAIL mp_counts mp=%0d br=%0d exp=1/1", mp_count, br_count); end
    endtask

    task automatic test_wrong_target_alias();
        logic [31:0] br0;
        jump_E = 1; pc_E = 32'h120; pred_taken_E = 1;
        pred_target_E = 32'h300; pc_target_E = 32'h304; #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL wrong_target mp got=%b exp=1", mispredict); end
        step();
        clear_inputs();
        checks++; if (pc_F !== 32'h304) begin errors++; $display("FAIL wrong_target pc got=%h exp=304", pc_F); end
        br0 = br_count;
        pc_E = 32'h50; pred_taken_E = 1; taken_E = 1; pc_target_E = 32'h999; #1;
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h54) begin errors++; $display("FAIL alias mp=%b rd=%h exp=1/54", mispredict, redirect_pc); end
        step();
        clear_inputs();
        checks++; if (br_count !== br0 || pc_F !== 32'h54) begin errors++; $display("FAIL alias_after br=%0d pc=%h exp=%0d/54", br_count, pc_F, br0); end
        // correctly predicted jump: no redirect
        jump_E = 1; pc_E = 32'h60; pred_taken_E = 1; pred_target_E = 32'h80; pc_target_E = 32'h80; #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL jump_ok mp got=%b exp=0", mispredict); end
        step();
        clear_inputs();
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        checks++; if (pc_F !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got=%h exp=fffffffc", pc_F); end
        step();
        checks++; if (pc_F !== 32'h0) begin errors++; $display("FAIL wrap got=%h exp=0", pc_F); end
        // same-cycle read and write of one index sees the old counter
        goto_pc(32'h140);
        stall_F = 1; btb_hit = 1; btb_target = 32'h500;
        jump_E = 1; pc_E = 32'h140; pred_taken_E = 1; pred_target_E = 32'h180; pc_target_E = 32'h180; #1;
        checks++; if (pred_taken_F !== 1'b0) begin errors++; $display("FAIL rw_same_old got=%b exp=0", pred_taken_F); end
        step();
        jump_E = 0; pred_taken_E = 0; #1;
        checks++; if (pred_taken_F !== 1'b1) begin errors++; $display("FAIL rw_same_new got=%b exp=1", pred_taken_F); end
        clear_inputs();
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 400; k++) begin
            stall_F       = ($urandom % 4) == 0;
            btb_hit       = $urandom % 2;
            btb_target    = 32'($urandom_range(0, 255)) << 2;
            r             = int'($urandom % 4);
            branch_E      = (r == 0);
            jump_E        = (r == 1);
            taken_E       = $urandom % 2;
            pc_E          = 32'($urandom_range(0, 255)) << 2;
            pc_target_E   = 32'($urandom_range(0, 255)) << 2;
            pred_taken_E  = ($urandom % 3) == 0;
            pred_target_E = ($urandom % 2) ? pc_target_E : 32'($urandom_range(0, 255)) << 2;
            #1;
            checks++; if (mispredict !== m_mispredict()) begin errors++; $display("FAIL rnd_mp[%0d] got=%b exp=%b", k, mispredict, m_mispredict()); end
            if (m_mispredict()) begin
                checks++; if (redirect_pc !== m_redirect()) begin errors++; $display("FAIL rnd_redirect[%0d] got=%h exp=%h", k, redirect_pc, m_redirect()); end
            end
            checks++; if (pred_taken_F !== m_pred()) begin errors++; $display("FAIL rnd_pred[%0d] got=%b exp=%b", k, pred_taken_F, m_pred()); end
            step();
            checks++; if (pc_F !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", k, pc_F, m_pc); end
            checks++; if (br_count !== m_br || mp_count !== m_mp) begin errors++; $display("FAIL rnd_cnt[%0d] br=%0d mp=%0d exp=%0d/%0d", k, br_count, mp_count, m_br, m_mp); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential_stall();
        test_training();
        test_mispredict();
        test_wrong_target_alias();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
